// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter between the CPU load/store port (master 0)
// and the debug/DMA loader port (master 1) in front of a single-port data
// memory. One word access is accepted per cycle. Misaligned or out-of-range
// accesses are faulted and never reach the memory as writes. Each accepted
// access gets a registered response one cycle later.
module dm_arbiter #(
    parameter logic [31:0] ADDR_MAX = 32'h0000_2FFF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,

    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    // Master granted most recently; 1 after reset so master 0 wins first.
    logic        last_q, last_d;

    logic        m0_rvalid_q, m0_rvalid_d;
    logic [31:0] m0_rdata_q,  m0_rdata_d;
    logic        m0_err_q,    m0_err_d;
    logic        m1_rvalid_q, m1_rvalid_d;
    logic [31:0] m1_rdata_q,  m1_rdata_d;
    logic        m1_err_q,    m1_err_d;

    logic        gnt0, gnt1, granted;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic        fault;
    logic [31:0] resp_data;

    // Grant, request mux, fault check and memory drive for the current cycle.
    always_comb begin
        gnt0     = m0_req && (!m1_req || last_q);
        gnt1     = m1_req && (!m0_req || !last_q);
        granted  = gnt0 || gnt1;

        // With no grant the mux rests on master 0's fields.
        sel_we    = gnt1 ? m1_we    : m0_we;
        sel_addr  = gnt1 ? m1_addr  : m0_addr;
        mem_wdata = gnt1 ? m1_wdata : m0_wdata;
        mem_addr  = sel_addr;

        fault     = (sel_addr[1:0] != 2'b00) || (sel_addr > ADDR_MAX);
        mem_we    = granted && sel_we && !fault && !reset;

        // Writes and faulted accesses return zero data.
        resp_data = (sel_we || fault) ? 32'h0 : mem_rdata;
    end

    assign m0_ack = gnt0;
    assign m1_ack = gnt1;

    // Next-state for the round-robin pointer and both response registers.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        last_d      = last_q;
        m0_rvalid_d = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m0_err_d    = m0_err_q;
        m1_rvalid_d = 1'b0;
        m1_rdata_d  = m1_rdata_q;
        m1_err_d    = m1_err_q;

        if (gnt0) begin
            last_d      = 1'b0;
            m0_rvalid_d = 1'b1;
            m0_err_d    = fault;
            m0_rdata_d  = resp_data;
            m1_err_d    = 1'b0;
        end else if (gnt1) begin
            last_d      = 1'b1;
            m1_rvalid_d = 1'b1;
            m1_err_d    = fault;
            m1_rdata_d  = resp_data;
            m0_err_d    = 1'b0;
        end
    end

    // State registers; reset discards any access acked while it is asserted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q      <= 1'b1;
            m0_rvalid_q <= 1'b0;
            m0_rdata_q  <= 32'h0;
            m0_err_q    <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m1_rdata_q  <= 32'h0;
            m1_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together at the edge.
            last_q      <= last_d;
            m0_rvalid_q <= m0_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m0_err_q    <= m0_err_d;
            m1_rvalid_q <= m1_rvalid_d;
            m1_rdata_q  <= m1_rdata_d;
            m1_err_q    <= m1_err_d;
        end
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m0_err    = m0_err_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m1_rdata  = m1_rdata_q;
    assign m1_err    = m1_err_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: a behavioural 3072-word memory sits on
// the memory port; stimulus pushes hand-computed responses into per-master
// queues and a negedge monitor pops and compares whenever rvalid is high.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
    logic        m0_ack, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_ack, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t q0[$];
    resp_t q1[$];
    resp_t r0, r1;

    int total = 0;
    int passed = 0;

    dm_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on rising edge.
    // Unmapped addresses read back a marker so unzeroed fault data shows up.
    logic [31:0] mem [0:3071];
    assign mem_rdata = (mem_addr[31:2] < 30'd3072) ? mem[mem_addr[13:2]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (mem_we && mem_addr[31:2] < 30'd3072)
            mem[mem_addr[13:2]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    // Response monitor: every rvalid must match the oldest expected response.
    always @(negedge clk) begin
        if (m0_rvalid === 1'b1) begin
            if (q0.size() == 0) check("m0_spurious_rvalid", {31'h0, m0_rvalid}, 32'h0);
            else begin
                r0 = q0.pop_front();
                check("m0_rdata", m0_rdata, r0.rdata);
                check("m0_err", {31'h0, m0_err}, {31'h0, r0.err});
            end
        end
        if (m1_rvalid === 1'b1) begin
            if (q1.size() == 0) check("m1_spurious_rvalid", {31'h0, m1_rvalid}, 32'h0);
            else begin
                r1 = q1.pop_front();
                check("m1_rdata", m1_rdata, r1.rdata);
                check("m1_err", {31'h0, m1_err}, {31'h0, r1.err});
            end
        end
    end

    // One single-master access in the next cycle; requests stay driven so
    // calls can run back to back.
    task automatic access(input int m, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic exp_fault,
                          input logic [31:0] exp_rdata);
        resp_t e;
        @(posedge clk); #1;
        m0_req = (m == 0); m1_req = (m == 1);
        if (m == 0) begin m0_we = we; m0_addr = addr; m0_wdata = wdata; end
        else        begin m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        #2;
        check(m == 0 ? "m0_ack" : "m1_ack", {31'h0, (m == 0) ? m0_ack : m1_ack}, 32'h1);
        check("mem_we", {31'h0, mem_we}, {31'h0, we && !exp_fault});
        e.rdata = exp_rdata;
        e.err   = exp_fault;
        if (m == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            m0_req = 1'b0; m1_req = 1'b0;
        end
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_m0_rvalid"}, {31'h0, m0_rvalid}, 32'h0);
        check({tag, "_m0_rdata"},  m0_rdata, 32'h0);
        check({tag, "_m0_err"},    {31'h0, m0_err}, 32'h0);
        check({tag, "_m1_rvalid"}, {31'h0, m1_rvalid}, 32'h0);
        check({tag, "_m1_rdata"},  m1_rdata, 32'h0);
        check({tag, "_m1_err"},    {31'h0, m1_err}, 32'h0);
        check({tag, "_mem_we"},    {31'h0, mem_we}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resp_t e;
        for (int i = 0; i < 3072; i++) mem[i] = 32'h0;

        // Asynchronous reset asserted mid-cycle, then idle after release.
        #12 reset = 1'b1;
        #1 check_clear("reset");
        @(posedge clk); @(posedge clk); #1 reset = 1'b0;
        idle(3);
        #2 check_clear("idle");
        check("idle_m0_ack", {31'h0, m0_ack}, 32'h0);

        // Single-master write then read-back in the following cycle.
        access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
        access(0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF);
        access(1, 1'b1, 32'h0000_0004, 32'h0BAD_F00D, 1'b0, 32'h0);
        access(0, 1'b1, 32'h0000_0020, 32'hA5A5_0020, 1'b0, 32'h0);
        access(1, 1'b1, 32'h0000_2FFC, 32'hCAFE_2FFC, 1'b0, 32'h0);

        // Faults: misaligned write, out-of-range read, then unchanged data.
        access(1, 1'b1, 32'h0000_0006, 32'h1111_1111, 1'b1, 32'h0);
        access(0, 1'b0, 32'h0000_3000, 32'h0,         1'b1, 32'h0);
        access(0, 1'b0, 32'h0000_0004, 32'h0,         1'b0, 32'h0BAD_F00D);

        // Range boundary, including the unsigned wrap case.
        access(1, 1'b0, 32'h0000_2FFC, 32'h0, 1'b0, 32'hCAFE_2FFC);
        access(0, 1'b0, 32'h0000_2FFD, 32'h0, 1'b1, 32'h0);
        access(1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0);
        idle(2);

        // Continuous contention from reset: grants alternate starting at m0.
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0004;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            #2;
            check($sformatf("rr%0d_m0_ack", i), {31'h0, m0_ack}, {31'h0, (i % 2) == 0});
            check($sformatf("rr%0d_m1_ack", i), {31'h0, m1_ack}, {31'h0, (i % 2) == 1});
            if ((i % 2) == 0) begin e.rdata = 32'hDEAD_BEEF; e.err = 1'b0; q0.push_back(e); end
            else              begin e.rdata = 32'h0BAD_F00D; e.err = 1'b0; q1.push_back(e); end
        end
        idle(2);

        // Reset asserted inside the ack cycle of a write: nothing commits.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0020; m0_wdata = 32'h1234_5678;
        #1 reset = 1'b1;
        #1 check("midreset_mem_we", {31'h0, mem_we}, 32'h0);
        @(posedge clk); #1;
        m0_req = 1'b0; reset = 1'b0;
        #5 check("midreset_no_rvalid", {31'h0, m0_rvalid}, 32'h0);
        access(0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'hA5A5_0020);

        // First contention after reset goes to m0 (last_q was 1 then m0 read).
        // m0 just won, so the next contention goes to m1.
        @(posedge clk); #1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_2FFC;
        #2;
        check("post_m1_ack", {31'h0, m1_ack}, 32'h1);
        check("post_m0_ack", {31'h0, m0_ack}, 32'h0);
        e.rdata = 32'hCAFE_2FFC; e.err = 1'b0; q1.push_back(e);
        idle(1);

        // Fresh reset then contention: m0 must win the first one.
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        #2;
        check("first_contention_m0_ack", {31'h0, m0_ack}, 32'h1);
        check("first_contention_m1_ack", {31'h0, m1_ack}, 32'h0);
        e.rdata = 32'hDEAD_BEEF; e.err = 1'b0; q0.push_back(e);
        idle(3);

        check("q0_drained", q0.size(), 32'h0);
        check("q1_drained", q1.size(), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-port arbiter and sequencer in front of the single-port data memory (3072 words; combinational read, write on clock edge). It shares the memory between master 0, the CPU MEM-stage load/store port, and master 1, the debug/DMA loader port. It accepts at most one word access per cycle, using round-robin priority between the masters. Before driving the memory it checks alignment and address range. Read data and error status return with a registered one-cycle response.

## Interface
Parameters:
- ADDR_MAX, 32'h0000_2FFF, highest legal byte address (inclusive)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- m0_req  in  1  master 0 access request
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 store data
- m0_ack  out  1  master 0 request accepted this cycle (combinational)
- m0_rvalid  out  1  master 0 response valid (registered)
- m0_rdata  out  32  master 0 read data; valid with m0_rvalid
- m0_err  out  1  master 0 access faulted; valid with m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rvalid, m1_rdata, m1_err: same as master 0, for master 1
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data (combinational from mem_addr)

## Operation
- State:
  - `last` (1 bit): master granted most recently.
  - Response registers per master: rvalid, rdata, err.
- Grant, combinational:
  - Only one master requesting: that master wins.
  - Both requesting: the master != `last` wins.
  - Neither requesting: no grant.
  - Exactly one ack is high for a granted cycle; the losing master sees ack=0 and must hold its req and fields stable until acked.
- Fault check on the granted request: fault = (addr[1:0] != 0) || (addr > ADDR_MAX). Comparison is unsigned, 32-bit.
- Memory drive:
  - mem_addr, mem_wdata: the granted master's fields. With no grant, they hold master 0's fields.
  - mem_we = granted && we && !fault && !reset.
- Accept edge. On the rising edge where ackN=1:
  - `last` ← N.
  - rvalidN ← 1.
  - errN ← fault.
  - rdataN ← (we || fault) ? 0 : mem_rdata.
  - The other master's rvalid/err ← 0.
  - A write to a faulted address is never committed.
- No-grant edge: both rvalid ← 0. rdata and err hold their values, which are don't-care while rvalid=0.
- Write response: rvalid=1, rdata=0, err=fault.
- Reset values:
  - m0/m1 rvalid, err = 0.
  - rdata = 0.
  - `last` = 1, so master 0 wins the first contention.
  - mem_we = 0 while reset is high.
- Reset mid-transaction: an access acked in the same cycle reset asserts is discarded. No write is committed and no response is produced.

## Timing
- Ack latency: 0 cycles; ack is combinational from req and `last`.
- Response latency: exactly 1 cycle. The request is acked in cycle N; rvalid is high in cycle N+1 only, as a single-cycle pulse per accepted request.
- Throughput:
  - A single master requesting every cycle gets ack every cycle and rvalid every cycle from the second cycle on.
  - Under continuous contention, grants alternate 0,1,0,1…, so each master's worst-case wait is 1 cycle.
- Write commit: at the rising edge that ends the ack cycle. A read of the same address acked in cycle N+1 returns the new data.
- Read data is sampled from mem_rdata on the accept edge. The memory must present the data combinationally within that cycle.

## Test plan
- Reset then idle:
  - Assert reset asynchronously mid-cycle.
  - Required: all rvalid/err/rdata=0 and mem_we=0 immediately. After release with no req, outputs stay 0.
- Single-master write/read:
  - m0 writes 0xDEADBEEF to 0x0000_0010 in cycle N. Required: mem_we=1 in N and m0_rvalid=1, err=0, rdata=0 in N+1.
  - m0 reads 0x10 in N+1. Required: m0_rdata=0xDEADBEEF in N+2.
- Contention round-robin:
  - Both masters request continuously from reset.
  - Required: acks go m0,m1,m0,m1. Each rvalid pulses on alternate cycles, one cycle after its ack.
- Faults:
  - m1 writes 0x0000_0006. Required: mem_we=0; next cycle m1_err=1, m1_rdata=0.
  - m0 reads 0x0000_3000. Required: m0_err=1, m0_rdata=0.
  - A subsequent read of 0x4 returns the unchanged data.
- Boundary:
  - Read at 0x0000_2FFC. Required: err=0, data returned.
  - Read at 0x0000_2FFD. Required: err=1.
  - Read at 0xFFFF_FFFC. Required: err=1 (unsigned comparison).
- Reset mid-op:
  - m0 write to 0x20 acked in cycle N with reset asserted within N.
  - Required: memory word 0x20 is unchanged and no rvalid follows. After release, m0 wins the first contention.
